// File: rtl/rf_param_irq_pkg.sv
// Shared definitions for the parametrised register file: register offsets relative
// to NUM_REGS, CTRL bit positions and the start/busy FSM encoding.
package rf_param_irq_pkg;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_BUSY_BIT  = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } fsm_state_t;

   // The three special registers always occupy the top of the map.
   function automatic int ctrl_idx(input int num_regs);
      return num_regs - 3;
   endfunction

   function automatic int irq_en_idx(input int num_regs);
      return num_regs - 2;
   endfunction

   function automatic int irq_stat_idx(input int num_regs);
      return num_regs - 1;
   endfunction

endpackage

// File: rtl/rf_param_irq_w1c_reg.sv
// Status register: hardware set, software write-1-to-clear, set wins on collision.
module rf_param_irq_w1c_reg #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] hw_set,
   input  logic         clr_we,
   input  logic [W-1:0] clr_data,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;
   logic [W-1:0] q_next;

   assign q_next = (q_reg & ~({W{clr_we}} & clr_data)) | hw_set;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_reg <= '0;
      end else begin
         q_reg <= q_next;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/rf_param_irq.sv
// Slave-bus register file: GP config registers, CTRL start/busy FSM, IRQ enable/status
// and a registered read port plus a registered, masked interrupt.
module rf_param_irq
   import rf_param_irq_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int NUM_REGS = 23,
   parameter int IRQ_W    = 2
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            s_wr,
   input  logic                            s_rd,
   input  logic [ADDR_W-1:0]               s_addr,
   input  logic [DATA_W-1:0]               s_din,
   output logic [DATA_W-1:0]               s_dout,
   output logic                            s_rvalid,
   input  logic [IRQ_W-1:0]                hw_event,
   output logic                            hw_start,
   output logic                            busy,
   output logic [(NUM_REGS-3)*DATA_W-1:0]  gp_q,
   output logic                            interrupt_out
);

   localparam int NUM_GP = NUM_REGS - 3;
   localparam logic [ADDR_W-1:0] CTRL_ADDR     = ADDR_W'(ctrl_idx(NUM_REGS));
   localparam logic [ADDR_W-1:0] IRQ_EN_ADDR   = ADDR_W'(irq_en_idx(NUM_REGS));
   localparam logic [ADDR_W-1:0] IRQ_STAT_ADDR = ADDR_W'(irq_stat_idx(NUM_REGS));

   logic               ctrl_we;
   logic               en_we;
   logic               stat_we;
   logic               start_req;
   logic [IRQ_W-1:0]   irq_en_reg;
   logic [IRQ_W-1:0]   irq_stat;
   fsm_state_t         state_reg;
   logic               hw_start_reg;
   logic               busy_reg;
   logic [DATA_W-1:0]  rd_mux;
   logic [DATA_W-1:0]  s_dout_reg;
   logic               s_rvalid_reg;
   logic               irq_reg;

   assign ctrl_we   = s_wr && (s_addr == CTRL_ADDR);
   assign en_we     = s_wr && (s_addr == IRQ_EN_ADDR);
   assign stat_we   = s_wr && (s_addr == IRQ_STAT_ADDR);
   assign start_req = ctrl_we && s_din[CTRL_START_BIT];

   generate
      for (genvar gi = 0; gi < NUM_GP; gi++) begin : g_gp
         logic              gp_we;
         logic [DATA_W-1:0] gp_reg;

         assign gp_we = s_wr && (s_addr == ADDR_W'(gi));

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               gp_reg <= '0;
            end else if (gp_we) begin
               gp_reg <= s_din;
            end
         end

         assign gp_q[gi*DATA_W +: DATA_W] = gp_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_reg <= '0;
      end else if (en_we) begin
         irq_en_reg <= s_din[IRQ_W-1:0];
      end
   end

   rf_param_irq_w1c_reg #(
      .W (IRQ_W)
   ) u_irq_stat (
      .clk      (clk),
      .reset_n  (reset_n),
      .hw_set   (hw_event),
      .clr_we   (stat_we),
      .clr_data (s_din[IRQ_W-1:0]),
      .q        (irq_stat)
   );

   // Start pulse and busy are produced together so the datapath sees them aligned.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         hw_start_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         hw_start_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start_req) begin
                  state_reg    <= ST_BUSY;
                  hw_start_reg <= 1'b1;
                  busy_reg     <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (hw_event[0]) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_GP; i++) begin
         if (s_addr == ADDR_W'(i)) begin
            rd_mux = gp_q[i*DATA_W +: DATA_W];
         end
      end
      if (s_addr == CTRL_ADDR) begin
         rd_mux[CTRL_BUSY_BIT] = busy_reg;
      end
      if (s_addr == IRQ_EN_ADDR) begin
         rd_mux = DATA_W'(irq_en_reg);
      end
      if (s_addr == IRQ_STAT_ADDR) begin
         rd_mux = DATA_W'(irq_stat);
      end
   end

   // Read data is sampled from pre-edge state, so a same-cycle write is not visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_dout_reg   <= '0;
         s_rvalid_reg <= 1'b0;
         irq_reg      <= 1'b0;
      end else begin
         s_rvalid_reg <= s_rd;
         if (s_rd) begin
            s_dout_reg <= rd_mux;
         end
         irq_reg <= |(irq_stat & irq_en_reg);
      end
   end

   assign s_dout        = s_dout_reg;
   assign s_rvalid      = s_rvalid_reg;
   assign hw_start      = hw_start_reg;
   assign busy          = busy_reg;
   assign interrupt_out = irq_reg;

endmodule

// File: tb/tb_rf_param_irq.sv
// Scoreboard bench for rf_param_irq: reads queue their expected data, a negedge
// monitor pops and compares whenever s_rvalid is seen.
module tb_rf_param_irq;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int NR = 23;
   localparam int IW = 2;
   localparam int NG = NR - 3;
   localparam int GW = NG * DW;
   localparam logic [AW-1:0] A_CTRL = AW'(NR - 3);
   localparam logic [AW-1:0] A_EN   = AW'(NR - 2);
   localparam logic [AW-1:0] A_STAT = AW'(NR - 1);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          s_wr;
   logic          s_rd;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_din;
   logic [DW-1:0] s_dout;
   logic          s_rvalid;
   logic [IW-1:0] hw_event;
   logic          hw_start;
   logic          busy;
   logic [GW-1:0] gp_q;
   logic          interrupt_out;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } rd_exp_t;

   rd_exp_t       sb_q[$];
   logic [DW-1:0] gp_model [NG];
   int            n_checks = 0;
   int            n_errors = 0;

   always #5 clk = ~clk;

   rf_param_irq #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_REGS (NR),
      .IRQ_W    (IW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_wr          (s_wr),
      .s_rd          (s_rd),
      .s_addr        (s_addr),
      .s_din         (s_din),
      .s_dout        (s_dout),
      .s_rvalid      (s_rvalid),
      .hw_event      (hw_event),
      .hw_start      (hw_start),
      .busy          (busy),
      .gp_q          (gp_q),
      .interrupt_out (interrupt_out)
   );

   task automatic check_val(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   function automatic logic [GW-1:0] gp_flat();
      logic [GW-1:0] f;
      for (int i = 0; i < NG; i++) f[i*DW +: DW] = gp_model[i];
      return f;
   endfunction

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      @(negedge clk);
      s_wr = 1'b1; s_addr = addr; s_din = data;
      @(negedge clk);
      s_wr = 1'b0;
      if (addr < AW'(NG)) gp_model[addr] = data;
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
      rd_exp_t e;
      @(negedge clk);
      s_rd = 1'b1; s_addr = addr;
      e.addr = addr; e.data = exp;
      sb_q.push_back(e);
      @(negedge clk);
      s_rd = 1'b0;
   endtask

   task automatic pulse_event(input logic [IW-1:0] ev);
      @(negedge clk);
      hw_event = ev;
      @(negedge clk);
      hw_event = '0;
   endtask

   always @(negedge clk) begin
      rd_exp_t e;
      if (reset_n && s_rvalid) begin
         if (sb_q.size() == 0) begin
            check_val("sb_underflow", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check_val($sformatf("rdata@%0h", e.addr), s_dout, e.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_addr = '0; s_din = '0; hw_event = '0;
      for (int i = 0; i < NG; i++) gp_model[i] = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      check_val("rst_dout", s_dout, 0);
      check_val("rst_rvalid", s_rvalid, 0);
      check_val("rst_start", hw_start, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_irq", interrupt_out, 0);
      check_val("rst_gp_q", gp_q, 0);

      // Asynchronous reset in the middle of a busy operation
      do_write(0, 32'h0000_1234);
      do_write(A_CTRL, 32'h1);
      check_val("pre_rst_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check_val("async_busy", busy, 0);
      check_val("async_start", hw_start, 0);
      check_val("async_gp_q", gp_q, 0);
      check_val("async_rvalid", s_rvalid, 0);
      for (int i = 0; i < NG; i++) gp_model[i] = '0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < NR; i++) do_read(AW'(i), 0);

      // GP register write/readback
      do_write(3, 32'hA5A5_0001);
      do_read(3, 32'hA5A5_0001);
      check_val("gp3_slice", gp_q[4*DW-1:3*DW], 32'hA5A5_0001);
      for (int i = 0; i < NG; i++) do_write(AW'(i), (32'h0101_0101 * i) ^ 32'hDEAD_0000);
      check_val("gp_all", gp_q, gp_flat());
      for (int i = 0; i < NG; i += 7) do_read(AW'(i), (32'h0101_0101 * i) ^ 32'hDEAD_0000);

      // Start/busy handshake
      do_write(A_CTRL, 32'h1);
      check_val("start_pulse", hw_start, 1);
      check_val("busy_set", busy, 1);
      @(negedge clk);
      check_val("start_one_cycle", hw_start, 0);
      do_write(A_CTRL, 32'h1);
      check_val("no_restart", hw_start, 0);
      check_val("still_busy", busy, 1);
      do_read(A_CTRL, 32'h2);
      pulse_event(2'b01);
      check_val("busy_cleared", busy, 0);
      do_read(A_CTRL, 32'h0);

      // Interrupt masking and lag
      do_write(A_EN, 32'hFFFF_FFFD);
      do_read(A_EN, 32'h1);
      do_write(A_STAT, 32'h3);
      @(negedge clk);
      check_val("irq_idle", interrupt_out, 0);
      pulse_event(2'b10);
      check_val("irq_masked_a", interrupt_out, 0);
      @(negedge clk);
      check_val("irq_masked_b", interrupt_out, 0);
      do_read(A_STAT, 32'h2);
      pulse_event(2'b01);
      check_val("irq_lag", interrupt_out, 0);
      check_val("idle_event_fsm", busy, 0);
      @(negedge clk);
      check_val("irq_asserted", interrupt_out, 1);
      do_read(A_STAT, 32'h3);
      do_write(A_STAT, 32'h1);
      check_val("irq_lag_clr", interrupt_out, 1);
      @(negedge clk);
      check_val("irq_deasserted", interrupt_out, 0);
      do_read(A_STAT, 32'h2);

      // Hardware set collides with W1C clear
      @(negedge clk);
      s_wr = 1'b1; s_addr = A_STAT; s_din = 32'h1; hw_event = 2'b01;
      @(negedge clk);
      s_wr = 1'b0; hw_event = '0;
      do_read(A_STAT, 32'h3);

      // Read and write to the same index in one cycle
      @(negedge clk);
      begin
         rd_exp_t e;
         s_wr = 1'b1; s_rd = 1'b1; s_addr = 5; s_din = 32'hCAFE_F00D;
         e.addr = 5; e.data = gp_model[5];
         sb_q.push_back(e);
      end
      @(negedge clk);
      s_wr = 1'b0; s_rd = 1'b0;
      gp_model[5] = 32'hCAFE_F00D;
      do_read(5, 32'hCAFE_F00D);

      // Out-of-range and aliasing addresses
      do_write(AW'(NR + 5), 32'hFFFF_FFFF);
      check_val("oor_no_change", gp_q, gp_flat());
      do_read(AW'(NR + 5), 0);
      do_write(16'h8003, 32'h1111_2222);
      check_val("alias_no_change", gp_q, gp_flat());
      do_read(16'h8003, 0);
      do_write(16'h8000 | A_CTRL, 32'h1);
      check_val("alias_no_start", busy, 0);

      repeat (3) @(negedge clk);
      check_val("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
